// File: rtl/sprite_track_pkg.sv
// Shared encodings for the sprite track controller.
//   dir_e   : movement request decoded from one player's up/down buttons
//   state_e : per-channel press/auto-repeat FSM states
//   decode_dir() : up/down levels -> dir_e. Both buttons held counts as no request.
package sprite_track_pkg;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } dir_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_e;

  function automatic dir_e decode_dir(input logic up, input logic down);
    dir_e d;
    d = DIR_NONE;
    if (up && !down)      d = DIR_UP;
    else if (down && !up) d = DIR_DOWN;
    return d;
  endfunction

endpackage

// File: rtl/sprite_track_channel.sv
// One sprite channel: press-then-auto-repeat FSM, hold/repeat tick counter,
// clamped Y stepping and a one-cycle moved pulse.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   tick           : movement enable; inputs are only acted on in tick cycles
//   recentre       : synchronous return to INIT_Y / IDLE, overrides everything
//   up, down       : debounced button levels for this player
//   top_y          : registered sprite top-Y
//   at_top         : top_y == 0
//   at_bottom      : top_y == MAX_Y
//   moved          : registered pulse, high for the cycle after top_y changed
module sprite_track_channel
  import sprite_track_pkg::*;
#(
  parameter int Y_W          = 6,
  parameter int MAX_Y        = 42,
  parameter int STEP         = 2,
  parameter int INIT_Y       = 21,
  parameter int HOLD_TICKS   = 8,
  parameter int REPEAT_TICKS = 2,
  parameter int CNT_W        = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           tick,
  input  logic           recentre,
  input  logic           up,
  input  logic           down,
  output logic [Y_W-1:0] top_y,
  output logic           at_top,
  output logic           at_bottom,
  output logic           moved
);

  localparam int YW1 = Y_W + 1;

  localparam logic [Y_W-1:0]   STEP_Y      = Y_W'(STEP);
  localparam logic [Y_W-1:0]   MAX_Y_V     = Y_W'(MAX_Y);
  localparam logic [Y_W-1:0]   INIT_Y_V    = Y_W'(INIT_Y);
  localparam logic [Y_W:0]     STEP_WIDE   = YW1'(STEP);
  localparam logic [Y_W:0]     MAX_WIDE    = YW1'(MAX_Y);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] REPEAT_LOAD = CNT_W'(REPEAT_TICKS - 1);

  state_e           state;
  dir_e             latched;
  dir_e             dir;
  logic [CNT_W-1:0] cnt;
  logic [Y_W:0]     sum;
  logic [Y_W-1:0]   step_y;

  // Candidate position if a step is taken this tick in the requested direction.
  // The downward sum is one bit wider so the clamp sees the true overshoot.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    dir    = decode_dir(up, down);
    sum    = {1'b0, top_y} + STEP_WIDE;
    step_y = top_y;
    case (dir)
      DIR_UP:   step_y = (top_y < STEP_Y) ? '0 : top_y - STEP_Y;
      DIR_DOWN: step_y = (sum > MAX_WIDE) ? MAX_Y_V : sum[Y_W-1:0];
      default:  step_y = top_y;
    endcase
  end

  // A clamped step still advances the FSM timing; moved only reports a real change.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      top_y   <= INIT_Y_V;
      state   <= IDLE;
      latched <= DIR_NONE;
      cnt     <= '0;
      moved   <= 1'b0;
    end else if (recentre) begin
      top_y   <= INIT_Y_V;
      state   <= IDLE;
      latched <= DIR_NONE;
      cnt     <= '0;
      moved   <= 1'b0;
    end else begin
      moved <= 1'b0;
      if (tick) begin
        case (state)
          IDLE: begin
            if (dir != DIR_NONE) begin
              top_y   <= step_y;
              moved   <= (step_y != top_y);
              latched <= dir;
              cnt     <= HOLD_LOAD;
              state   <= DELAY;
            end
          end
          DELAY: begin
            if (dir == DIR_NONE) begin
              latched <= DIR_NONE;
              state   <= IDLE;
            end else if (dir != latched) begin
              // Reversal is treated as a fresh press: step now, restart the hold delay.
              top_y   <= step_y;
              moved   <= (step_y != top_y);
              latched <= dir;
              cnt     <= HOLD_LOAD;
            end else if (cnt == '0) begin
              top_y <= step_y;
              moved <= (step_y != top_y);
              cnt   <= REPEAT_LOAD;
              state <= REPEAT;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          REPEAT: begin
            if (dir == DIR_NONE) begin
              latched <= DIR_NONE;
              state   <= IDLE;
            end else if (dir != latched) begin
              top_y   <= step_y;
              moved   <= (step_y != top_y);
              latched <= dir;
              cnt     <= HOLD_LOAD;
              state   <= DELAY;
            end else if (cnt == '0) begin
              top_y <= step_y;
              moved <= (step_y != top_y);
              cnt   <= REPEAT_LOAD;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: begin
            latched <= DIR_NONE;
            state   <= IDLE;
          end
        endcase
      end
    end
  end

  assign at_top    = (top_y == '0);
  assign at_bottom = (top_y == MAX_Y_V);

endmodule

// File: rtl/sprite_track_ctrl.sv
// Vertical-position controller for NUM_PLAYERS OLED sprites. Fans tick and
// recentre out to one sprite_track_channel per player and packs the results.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   tick           : one-cycle movement strobe (frame rate)
//   recentre       : synchronous recentre of all sprites
//   up, down       : per-player button levels
//   top_y          : packed top-Y, player i at [i*Y_W +: Y_W]
//   at_top         : per-player top_y == 0
//   at_bottom      : per-player top_y == SCREEN_H - SPRITE_H
//   moved          : per-player one-cycle pulse when top_y changed
module sprite_track_ctrl
  import sprite_track_pkg::*;
#(
  parameter int NUM_PLAYERS  = 2,
  parameter int Y_W          = 6,
  parameter int SCREEN_H     = 64,
  parameter int SPRITE_H     = 22,
  parameter int STEP         = 2,
  parameter int INIT_Y       = 21,
  parameter int HOLD_TICKS   = 8,
  parameter int REPEAT_TICKS = 2,
  parameter int CNT_W        = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       tick,
  input  logic                       recentre,
  input  logic [NUM_PLAYERS-1:0]     up,
  input  logic [NUM_PLAYERS-1:0]     down,
  output logic [NUM_PLAYERS*Y_W-1:0] top_y,
  output logic [NUM_PLAYERS-1:0]     at_top,
  output logic [NUM_PLAYERS-1:0]     at_bottom,
  output logic [NUM_PLAYERS-1:0]     moved
);

  localparam int MAX_Y = SCREEN_H - SPRITE_H;

  // Reject parameter sets the datapath cannot represent.
  if (SPRITE_H >= SCREEN_H) begin : g_bad_sprite_h
    $error("sprite_track_ctrl: SPRITE_H must be below SCREEN_H");
  end
  if (INIT_Y > MAX_Y) begin : g_bad_init_y
    $error("sprite_track_ctrl: INIT_Y must not exceed SCREEN_H - SPRITE_H");
  end
  if (SCREEN_H > (1 << Y_W)) begin : g_bad_y_w
    $error("sprite_track_ctrl: Y_W too narrow for SCREEN_H");
  end
  if (HOLD_TICKS < 1 || REPEAT_TICKS < 1) begin : g_bad_ticks
    $error("sprite_track_ctrl: HOLD_TICKS and REPEAT_TICKS must be at least 1");
  end
  if ((HOLD_TICKS - 1) >= (1 << CNT_W) || (REPEAT_TICKS - 1) >= (1 << CNT_W)) begin : g_bad_cnt_w
    $error("sprite_track_ctrl: CNT_W too narrow for the tick delays");
  end

  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_chan
    sprite_track_channel #(
      .Y_W          (Y_W),
      .MAX_Y        (MAX_Y),
      .STEP         (STEP),
      .INIT_Y       (INIT_Y),
      .HOLD_TICKS   (HOLD_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS),
      .CNT_W        (CNT_W)
    ) u_chan (
      .clk       (clk),
      .reset_n   (reset_n),
      .tick      (tick),
      .recentre  (recentre),
      .up        (up[i]),
      .down      (down[i]),
      .top_y     (top_y[i*Y_W +: Y_W]),
      .at_top    (at_top[i]),
      .at_bottom (at_bottom[i]),
      .moved     (moved[i])
    );
  end

endmodule
